// File: rtl/reload_divider_pkg.sv
// Shared definitions for the reload divider and its companion up-counter:
// state encoding and the default register width.
package reload_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/reload_divider.sv
// Programmable divider on a loadable down-counter: one-cycle tick at terminal
// count plus a near-50% clk_out, with divisor updates shadowed until reload.
module reload_divider
  import reload_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             clk_out,
  output logic             pending,
  output logic             running
);

  state_t           state, state_next;
  logic [WIDTH-1:0] active, active_next;
  logic [WIDTH-1:0] shadow, shadow_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload;
  logic             pending_next;
  logic             clk_out_next;

  assign running = (state == RUN);
  assign tick    = (state == RUN) && en && (count == '0);

  always_comb begin
    state_next   = state;
    active_next  = active;
    shadow_next  = shadow;
    count_next   = count;
    pending_next = pending;
    clk_out_next = clk_out;
    reload       = active;

    case (state)
      IDLE: begin
        if (ld) begin
          state_next   = RUN;
          active_next  = din;
          count_next   = din;
          clk_out_next = din > (din >> 1);
        end
      end
      RUN: begin
        if (en) begin
          if (count == '0) begin
            // A load landing on terminal count bypasses the shadow entirely.
            if (ld) begin
              reload = din;
            end else if (pending) begin
              reload = shadow;
            end else begin
              reload = active;
            end
            active_next  = reload;
            count_next   = reload;
            pending_next = 1'b0;
          end else begin
            count_next = count - 1'b1;
          end
          clk_out_next = count_next > (active_next >> 1);
        end
        if (ld && !tick) begin
          shadow_next  = din;
          pending_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      active  <= '0;
      shadow  <= '0;
      count   <= '0;
      pending <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      state   <= state_next;
      active  <= active_next;
      shadow  <= shadow_next;
      count   <= count_next;
      pending <= pending_next;
      clk_out <= clk_out_next;
    end
  end

endmodule
